result_streamer: RTL

RESULT_STREAMER -- requirements
Module: result_streamer

---
 rtl/result_streamer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/result_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : result_streamer
//  Purpose  : Captures a finished result matrix and streams it out one element
//             per valid/ready transfer in row-major order.
//  Revision : 1.0  initial release
// ============================================================================
module result_streamer #(
    parameter int ELEM_W = 15,
    parameter int ROWS   = 5,
    parameter int COLS   = 3
) (
    input  logic                          Clk,
    input  logic                          Rst_n,
    input  logic [ROWS*COLS*ELEM_W-1:0]   MatrixResult,
    input  logic                          Finished,
    input  logic                          OutReady,
    output logic [ELEM_W-1:0]             OutData,
    output logic [2:0]                    OutRow,
    output logic [1:0]                    OutCol,
    output logic                          OutValid,
    output logic                          OutLast,
    output logic                          Busy,
    output logic                          Done,
    output logic                          Overrun
);

    localparam int c_N     = ROWS * COLS;
    localparam int c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_fin_q;
    logic [ELEM_W-1:0]   w_elems [c_N];
    logic [ELEM_W-1:0]   r_buf   [c_N];
    logic [c_IDX_W-1:0]  r_idx;
    logic [2:0]          r_row;
    logic [1:0]          r_col;
    logic                r_done;
    logic                r_overrun;

    logic                w_rise;
    logic                w_stream;
    logic                w_xfer;
    logic                w_last;
    logic                w_capture;

    // Element 0 ([0][0]) sits in the most significant slice of the input.
    for (genvar gi = 0; gi < c_N; gi++) begin : g_unpack
        assign w_elems[gi] = MatrixResult[(c_N-1-gi)*ELEM_W +: ELEM_W];
    end

    assign w_rise   = Finished & ~r_fin_q;
    assign w_stream = (r_state == ST_STREAM);
    assign w_xfer   = w_stream & OutReady;
    assign w_last   = (r_idx == c_IDX_W'(c_N-1));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ST_STREAM;
                    w_capture   = 1'b1;
                end
            end
            ST_STREAM: begin
                if (w_xfer && w_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_fin_q   <= 1'b0;
            r_idx     <= '0;
            r_row     <= 3'd0;
            r_col     <= 2'd0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            for (int i = 0; i < c_N; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_fin_q <= Finished;
            r_done  <= w_xfer & w_last;
            // An edge on the final-transfer cycle still sees STREAM and is dropped.
            if (w_rise && w_stream) begin
                r_overrun <= 1'b1;
            end
            if (w_capture) begin
                for (int i = 0; i < c_N; i++) begin
                    r_buf[i] <= w_elems[i];
                end
                r_idx <= '0;
                r_row <= 3'd0;
                r_col <= 2'd0;
            end else if (w_xfer) begin
                if (w_last) begin
                    r_idx <= '0;
                    r_row <= 3'd0;
                    r_col <= 2'd0;
                end else begin
                    r_idx <= r_idx + c_IDX_W'(1);
                    if (r_col == 2'(COLS-1)) begin
                        r_col <= 2'd0;
                        r_row <= r_row + 3'd1;
                    end else begin
                        r_col <= r_col + 2'd1;
                    end
                end
            end
        end
    end

    assign OutValid = w_stream;
    assign Busy     = w_stream;
    assign OutLast  = w_stream & w_last;
    assign OutData  = w_stream ? r_buf[r_idx] : '0;
    assign OutRow   = w_stream ? r_row : 3'd0;
    assign OutCol   = w_stream ? r_col : 2'd0;
    assign Done     = r_done;
    assign Overrun  = r_overrun;

endmodule
`default_nettype wire
